uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered UART transmit path: the CPU side pushes bytes into an internal FIFO, and a serializer drains it as 8N1 frames, LSB first, on `tx`. It mirrors the receive path's RX-FIFO arrangement for the opposite direction. The CPU can issue `sb` writes back-to-back without waiting for each frame to finish. A 32-bit status word is exported for the memory-mapped read path.

## Interface
- `CLKS_PER_BIT`, 16: UART_CLK cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, 16: byte entries; power of two, 2..128.
- `UART_CLK` input 1: single clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `write_req` input 1: CPU store strobe, level; a rising edge pushes one byte.
- `write_data` input 8: byte to push, sampled on the push edge.
- `clear_overflow` input 1: synchronous clear of the sticky overflow flag.
- `tx` output 1: serial line; idles high.
- `tx_busy` output 1: high when the serializer is not IDLE or the FIFO is non-empty.
- `fifo_full` output 1: count == FIFO_DEPTH.
- `fifo_empty` output 1: count == 0.
- `overflow` output 1: sticky; set when a push is attempted while full.
- `status_word` output 32: {16'b0, count zero-extended to 8 bits, 4'b0, overflow, fifo_full, fifo_empty, tx_busy}.

## Operation
- Reset (`reset_n` low) takes effect immediately and sets:
  - `tx` = 1, state = IDLE.
  - Read/write pointers and count = 0; the FIFO is emptied, including any frame in flight.
  - `overflow` = 0 and the edge-detect register = 0.
  - `status_word` = 32'h0000_0002.
- Push edge detection: `push_evt` = `write_req` & ~`write_req_prev`, with `write_req_prev` registered each edge. A level held high pushes once.
- `write_req` high at reset release counts as a rising edge on the first clock.
- Push when `push_evt`:
  - If count < FIFO_DEPTH: write `write_data` at the write pointer, then increment the pointer (wraps modulo FIFO_DEPTH) and count.
  - If full: discard the byte and set `overflow`. `fifo_full` is the registered value, so a pop in the same cycle does not rescue the push.
- Overflow flag: `clear_overflow` clears it. If a rejected push and `clear_overflow` occur in the same cycle, set wins.
- Serializer FSM, with a bit-timer (0..CLKS_PER_BIT-1) and a bit index (0..7):
  - IDLE: `tx` = 1. If count != 0, pop the head into the shift register, advance the read pointer, and go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: `tx` = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Simultaneous push and pop: both take effect and count is unchanged.
- A pop only happens on a non-empty FIFO, so a byte cannot be pushed and popped in the same edge.
- `tx` is driven from a register and is glitch-free.

## Timing
- Push at edge E0 makes count visible after E0. `fifo_empty`, `fifo_full` and `status_word` all update after E0.
- First byte into an idle block:
  - IDLE pops at E1, and `tx` falls after E1 (1-cycle latency from the push edge).
  - The frame occupies exactly 10·CLKS_PER_BIT cycles from E1.
- Back-to-back frames: each STOP is followed by exactly one IDLE cycle with `tx` = 1. The next start bit follows, so the frame period is 10·CLKS_PER_BIT + 1 cycles.
- `tx_busy` rises after E0 and falls after the IDLE edge that finds count == 0 following the last STOP.
- Reset asserted mid-frame truncates the frame, with `tx` = 1 immediately. No partial byte resumes after release.

## Test plan
- Reset with `write_req` = 0 → `tx` = 1, `status_word` = 32'h0000_0002; the line stays high for 100 cycles.
- CLKS_PER_BIT = 4, push 8'hA5 → `tx` falls 1 cycle after the push edge. The bit sequence is 0,1,0,1,0,0,1,0,1,1, with each bit held 4 cycles. `tx_busy` falls 41 cycles after the push edge.
- Hold `write_req` high for 50 cycles → exactly one byte is transmitted; count never exceeds 1.
- Push bytes 8'h00..8'h11 (18 pushes) with FIFO_DEPTH = 16 while the line is busy:
  - `fifo_full` asserts, and the 17th–18th pushes are dropped as long as the FIFO is still full at the push edge.
  - `overflow` = 1 and stays set until `clear_overflow` is pulsed.
  - The transmitted order matches the pushes, and the read pointer wraps correctly.
- Push a new byte on the same edge the serializer pops (count = 1 → stays 1) → both bytes are transmitted in order, with a 1-cycle gap between frames.
- Assert `reset_n` low during data bit 3 of 8'h3C while 4 bytes are queued → `tx` = 1 immediately and count = 0. After release, no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO fed by CPU store strobes,
// drained LSB-first by a registered serializer.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        UART_CLK,
  input  logic        reset_n,
  input  logic        write_req,
  input  logic [7:0]  write_data,
  input  logic        clear_overflow,
  output logic        tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow,
  output logic [31:0] status_word
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [15:0]   BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          wr_prev_q;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic push_evt;
  logic push_ok;
  logic pop;
  logic bit_done;

  assign fifo_full  = (cnt_q == DEPTH_C);
  assign fifo_empty = (cnt_q == '0);
  assign tx_busy    = (state_q != IDLE) | ~fifo_empty;
  assign overflow   = ovf_q;
  assign tx         = tx_q;
  assign status_word = {16'h0, 8'(cnt_q), 4'h0,
                        ovf_q, fifo_full, fifo_empty, tx_busy};

  // Full is the registered count, so a same-edge pop never rescues a push.
  assign push_evt = write_req & ~wr_prev_q;
  assign push_ok  = push_evt & ~fifo_full;
  assign pop      = (state_q == IDLE) & ~fifo_empty;
  assign bit_done = (timer_q == BIT_LAST);

  always_comb begin
    wptr_d = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
    cnt_d  = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d  = ovf_q;
    if (push_evt & fifo_full) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        timer_d = '0;
        if (pop) begin
          shift_d = mem_q[rptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge UART_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      wr_prev_q <= write_req;
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge UART_CLK) begin
    if (push_ok) begin
      mem_q[wptr_q] <= write_data;
    end
  end

endmodule
